// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bundle between N requesters and the shared 4-way select datapath.
// master = requester side, slave = arbiter side.
interface rr_mux_arbiter_if #(
    parameter int N = 4
) ();
    localparam int SW = $clog2(N);

    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          valid;
    logic          timeout;

    modport master (output req, done, input grant, sel, valid, timeout);
    modport slave  (input req, done, output grant, sel, valid, timeout);
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbitration for a shared select datapath; 1 edge from req to grant.
// Grant held until done, request drop, or hold limit; each grant is followed by a one-cycle RELEASE bubble.
module rr_mux_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux_arbiter_if.slave  bus
);
    localparam int SW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [SW-1:0] LAST_IDX  = SW'(N - 1);
    localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;

    logic [SW-1:0] pick;
    logic          any_req;
    logic          owner_req;
    logic          limit_hit;

    assign any_req   = |bus.req;
    assign owner_req = bus.req[sel_q];
    assign limit_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    // Scan from the far end downward so the requester nearest ptr is written last and wins.
    always_comb begin
        int idx;
        idx  = 0;
        pick = ptr_q;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % N;
            if (bus.req[idx]) pick = SW'(idx);
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                grant_d = '0;
                valid_d = 1'b0;
                state_d = IDLE;
                if (any_req) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    grant_d = ONE << pick;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (bus.done || !owner_req || limit_hit) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    hold_d    = '0;
                    ptr_d     = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
                    timeout_d = limit_hit && !bus.done && owner_req;
                end else if (MAX_HOLD != 0) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;
endmodule
